// File: rtl/sharpen_core.sv
// sharpen_core: 3x3 Laplacian unsharp-mask sharpener on an AXI-stream pixel pipeline
// Ports: clk/rst_n (async active-low); di_00..di_22 3x3 luma window (di_11 centre);
// in_org_pixels RGB {c2,c1,c0} for the centre; s_axis_* input handshake/sideband;
// gain sharpening gain (scale 1/16, latched per frame); m_axis_* sharpened RGB stream.
module sharpen_core #(
  parameter int PXL_D_WIDTH  = 8,
  parameter int IN_HORZ_SIZE = 1280,
  parameter int IN_VERT_SIZE = 720,
  parameter int GAIN_W       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PXL_D_WIDTH-1:0]     di_00,
  input  logic [PXL_D_WIDTH-1:0]     di_01,
  input  logic [PXL_D_WIDTH-1:0]     di_02,
  input  logic [PXL_D_WIDTH-1:0]     di_10,
  input  logic [PXL_D_WIDTH-1:0]     di_11,
  input  logic [PXL_D_WIDTH-1:0]     di_12,
  input  logic [PXL_D_WIDTH-1:0]     di_20,
  input  logic [PXL_D_WIDTH-1:0]     di_21,
  input  logic [PXL_D_WIDTH-1:0]     di_22,
  input  logic [3*PXL_D_WIDTH-1:0]   in_org_pixels,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic [GAIN_W-1:0]          gain,
  output logic [3*PXL_D_WIDTH-1:0]   m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
);
  localparam int P  = PXL_D_WIDTH;
  localparam int LW = P + 4;
  localparam int DW = LW + GAIN_W;
  typedef enum logic {SYNC, ACTIVE} state_t;
  state_t state;
  logic [10:0] col, pc;
  logic [9:0] row, pr;
  logic [GAIN_W-1:0] gain_r;
  logic take, eol, eof, bord;
  logic [LW-1:0] nsum;
  logic signed [LW-1:0] lap, lap1;
  logic signed [DW:0] prod;
  logic signed [DW-1:0] d2;
  logic v1, u1, l1, b1, v2, u2, l2;
  logic [3*P-1:0] o1, o2;
  function automatic logic [P-1:0] clamp(input logic [P-1:0] o, input logic signed [DW-1:0] d);
    logic signed [DW:0] s;
    s = (DW+1)'($signed({1'b0, o})) + (DW+1)'(d);
    return s[DW] ? '0 : |s[DW-1:P] ? '1 : s[P-1:0];
  endfunction
  assign s_axis_tready = m_axis_tready;
  // a tuser beat is position (0,0) regardless of the counters, which also resynchronises
  always_comb begin
    take = s_axis_tvalid & m_axis_tready & (s_axis_tuser | state == ACTIVE);
    pc   = s_axis_tuser ? '0 : col;
    pr   = s_axis_tuser ? '0 : row;
    eol  = s_axis_tlast | pc == 11'(IN_HORZ_SIZE-1);
    eof  = eol & pr == 10'(IN_VERT_SIZE-1);
    bord = pc == '0 | pc == 11'(IN_HORZ_SIZE-1) | pr == '0 | pr == 10'(IN_VERT_SIZE-1);
    nsum = LW'(di_00) + LW'(di_01) + LW'(di_02) + LW'(di_10) + LW'(di_12)
         + LW'(di_20) + LW'(di_21) + LW'(di_22);
    lap  = $signed((LW'(di_11) << 3) - nsum);
    prod = (DW+1)'(lap1) * (DW+1)'($signed({1'b0, gain_r}));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= SYNC;
      col    <= '0;
      row    <= '0;
      gain_r <= '0;
    end else if (take) begin
      if (s_axis_tuser) gain_r <= gain;
      col   <= eol ? '0 : pc + 11'd1;
      row   <= eof ? '0 : eol ? pr + 10'd1 : pr;
      state <= eof ? SYNC : ACTIVE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {v1, u1, l1, b1, lap1, o1} <= '0;
      {v2, u2, l2, d2, o2} <= '0;
      {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} <= '0;
    end else if (m_axis_tready) begin
      v1   <= take;
      u1   <= s_axis_tuser & take;
      l1   <= s_axis_tlast & take;
      b1   <= bord;
      lap1 <= lap;
      o1   <= in_org_pixels;
      v2   <= v1;
      u2   <= u1;
      l2   <= l1;
      d2   <= b1 ? '0 : DW'(prod >>> 4);
      o2   <= o1;
      m_axis_tvalid <= v2;
      m_axis_tuser  <= u2;
      m_axis_tlast  <= l2;
      m_axis_tdata  <= {clamp(o2[2*P +: P], d2), clamp(o2[P +: P], d2), clamp(o2[0 +: P], d2)};
    end
endmodule

// File: doc/sharpen_core.md
SHARPEN_CORE -- requirements
Module: sharpen_core

Interface
REQ-001 SHALL have parameter PXL_D_WIDTH, default 8, bits per pixel component.
REQ-002 SHALL have parameter IN_HORZ_SIZE, default 1280, active pixels per line.
REQ-003 SHALL have parameter IN_VERT_SIZE, default 720, active lines per frame.
REQ-004 SHALL have parameter GAIN_W, default 4, sharpening gain width (unsigned, scale 1/16).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports di_00..di_22  input  PXL_D_WIDTH each  3x3 luma window, row-major, di_11 = centre.
REQ-008 SHALL have port in_org_pixels  input  3*PXL_D_WIDTH  original RGB {c2,c1,c0} aligned with the centre.
REQ-009 SHALL have ports s_axis_tvalid, s_axis_tuser, s_axis_tlast  input  1 each; s_axis_tready  output  1.
REQ-010 SHALL have port gain  input  GAIN_W  sharpening gain.
REQ-011 SHALL have port m_axis_tdata  output  3*PXL_D_WIDTH  sharpened RGB {c2,c1,c0}.
REQ-012 SHALL have ports m_axis_tvalid, m_axis_tuser, m_axis_tlast  output  1 each; m_axis_tready  input  1.

Function
REQ-013 SHALL drive s_axis_tready = m_axis_tready combinationally; input beat accepted when s_axis_tvalid & m_axis_tready.
REQ-014 SHALL implement a 3-stage pipeline (S1 Laplacian, S2 gain, S3 add/clamp); each accepted beat appears at the output exactly 3 advancing cycles later.
REQ-015 SHALL advance all stages only when m_axis_tready=1; when 0, all stage registers and outputs hold.
REQ-016 SHALL propagate valid per stage; an advancing cycle without an accepted beat inserts a bubble (tvalid=0).
REQ-017 SHALL carry tuser, tlast and in_org_pixels alongside data through all 3 stages unchanged.
REQ-018 S1 SHALL compute lap = 8*di_11 - sum(other 8), signed 12-bit, range -2040..+2040, no overflow.
REQ-019 S2 SHALL compute delta = (lap * gain_r) arithmetic-shift-right 4 (floor), signed 16-bit.
REQ-020 S3 SHALL compute each channel out_c = clamp(org_c + delta, 0, 255) independently.
REQ-021 SHALL force delta=0 (output = in_org_pixels) for border pixels: col==0, col==IN_HORZ_SIZE-1, row==0, or row==IN_VERT_SIZE-1.
REQ-022 SHALL have a 2-state FSM: SYNC (reset state) and ACTIVE.
REQ-023 In SYNC, accepted beats with tuser=0 SHALL be dropped (no output valid); an accepted beat with tuser=1 SHALL move to ACTIVE and be processed.
REQ-024 SHALL keep col (11-bit) and row (10-bit) counters giving position of the current accepted beat; a tuser=1 beat is col=0,row=0.
REQ-025 After an accepted beat with tlast=1 or col==IN_HORZ_SIZE-1: col<=0, row<=row+1; else col<=col+1.
REQ-026 Line end at row==IN_VERT_SIZE-1 SHALL return FSM to SYNC and row to 0.
REQ-027 tuser=1 in ACTIVE SHALL resynchronise: that beat becomes col=0,row=0.
REQ-028 SHALL latch gain into gain_r only on accepted tuser=1 beats; gain changes mid-frame have no effect.

Reset
REQ-029 On rst_n=0: FSM=SYNC, col=0, row=0, gain_r=0, all stage valids/tuser/tlast=0, data registers=0, m_axis_tdata=0.
REQ-030 Reset mid-frame SHALL discard in-flight beats; output resumes only after next tuser beat.

Verification
REQ-031 Flat window all 100, org (100,100,100), gain 8, interior pixel -> out (100,100,100) after 3 cycles.
REQ-032 Centre 200, neighbours 100, gain 1, org (100,50,0), interior -> lap 800, delta 50, out (150,100,50); gain 8 -> (255,255,255).
REQ-033 Centre 0, neighbours 255, gain 15, org (10,20,30), interior -> lap -2040, delta -1913, out (0,0,0).
REQ-034 Same stimulus as REQ-032 at col 0, col 1279, row 0, row 719 -> out equals org (100,50,0).
REQ-035 Full 1280x720 frame with random m_axis_tready deassertion -> 921600 output beats, order/tuser/tlast preserved, data held during stall.
REQ-036 Beats before first tuser dropped; rst_n pulse mid-frame -> m_axis_tvalid=0 until 3 cycles after next accepted tuser beat.
